axil_bram_bridge: RTL and testbench

AXI4-Lite slave that converts host register-path transactions into single-port block-RAM accesses. One instance sits directly downstream of each crossbar master port in the packet processor (instruction memory, 64 KB; data memory, 32 KB). It consumes the base-stripped AXI-Lite address and drives the host-side port of the core's IMEM/DMEM. Writes and reads are serialised onto the one memory port by a round-robin arbiter.

---
 rtl/axil_bram_bridge.sv | 177 +++++++++++++++++
 tb/tb_axil_bram_bridge.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave bridging host register traffic onto one single-port BRAM port.
// Ports: s_axil_* AXI-Lite slave; mem_* BRAM host port. Option: AXIL_BRIDGE_RANGE_CHK_EN.
module axil_bram_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [31:0]       s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] awaddr_q;
  logic [31:0] araddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        last_wr;
  logic        err_q;

  logic        aw_acc;
  logic        w_acc;
  logic        ar_acc;
  logic [31:0] wr_addr;
  logic [31:0] rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_p;
  logic        rd_p;
  logic        wr_gnt;
  logic        rd_gnt;
  logic        wr_bad;
  logic        rd_bad;
  logic        unused_addr;

  // A holding register is full while its ready is low. Requests being
  // accepted this very cycle are forwarded so they can issue at once.
  always_comb begin
    aw_acc  = s_axil_awvalid && s_axil_awready;
    w_acc   = s_axil_wvalid && s_axil_wready;
    ar_acc  = s_axil_arvalid && s_axil_arready;
    wr_addr = s_axil_awready ? s_axil_awaddr : awaddr_q;
    wr_data = s_axil_wready ? s_axil_wdata : wdata_q;
    wr_strb = s_axil_wready ? s_axil_wstrb : wstrb_q;
    rd_addr = s_axil_arready ? s_axil_araddr : araddr_q;
    wr_p    = (!s_axil_awready || aw_acc)
           && (!s_axil_wready || w_acc)
           && !s_axil_bvalid
           && (state != WR_ISSUE);
    rd_p    = (!s_axil_arready || ar_acc)
           && !s_axil_rvalid
           && (state != RD_ISSUE);
    // Round-robin: the side not granted last wins a tie.
    wr_gnt  = wr_p && (!rd_p || !last_wr);
    rd_gnt  = rd_p && !wr_gnt;
`ifdef AXIL_BRIDGE_RANGE_CHK_EN
    wr_bad  = (wr_addr >> ADDR_W) != 32'd0;
    rd_bad  = (rd_addr >> ADDR_W) != 32'd0;
`else
    wr_bad  = 1'b0;
    rd_bad  = 1'b0;
`endif
  end

  // Low address bits (and upper bits without the range check) are dropped.
  assign unused_addr = ^{wr_addr, rd_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_wr        <= 1'b0;
      err_q          <= 1'b0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      s_axil_awready <= 1'b1;
      s_axil_wready  <= 1'b1;
      s_axil_arready <= 1'b1;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= 2'b00;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= 2'b00;
      s_axil_rdata   <= '0;
      mem_en         <= 1'b0;
      mem_we         <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= '0;

      if (wr_gnt) begin
        s_axil_awready <= 1'b1;
        s_axil_wready  <= 1'b1;
      end else begin
        if (aw_acc) begin
          s_axil_awready <= 1'b0;
          awaddr_q       <= s_axil_awaddr;
        end
        if (w_acc) begin
          s_axil_wready <= 1'b0;
          wdata_q       <= s_axil_wdata;
          wstrb_q       <= s_axil_wstrb;
        end
      end

      // The read address stays held until its response is taken.
      if (ar_acc) begin
        s_axil_arready <= 1'b0;
        araddr_q       <= s_axil_araddr;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_arready <= 1'b1;
      end

      if (state == WR_ISSUE) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= err_q ? 2'b10 : 2'b00;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end

      if (state == RD_ISSUE) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rresp  <= err_q ? 2'b10 : 2'b00;
        s_axil_rdata  <= err_q ? 32'd0 : mem_rdata;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end

      // The port frees after every one-cycle issue, so grant each cycle.
      if (wr_gnt) begin
        state     <= WR_ISSUE;
        last_wr   <= 1'b1;
        err_q     <= wr_bad;
        mem_en    <= !wr_bad;
        mem_we    <= wr_bad ? 4'd0 : wr_strb;
        mem_addr  <= wr_addr[ADDR_W-1:2];
        mem_wdata <= wr_data;
      end else if (rd_gnt) begin
        state    <= RD_ISSUE;
        last_wr  <= 1'b0;
        err_q    <= rd_bad;
        mem_en   <= !rd_bad;
        mem_addr <= rd_addr[ADDR_W-1:2];
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Scoreboarded random + directed bench for axil_bram_bridge.
// Reference memory model predicts every B/R response.
module tb_axil_bram_bridge;
  localparam int AW = 16;
  localparam int NW = 1 << (AW - 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int men_cnt = 0;
  logic rnd_rdy = 1'b0;

  logic [31:0] ram  [0:NW-1];
  logic [31:0] refm [0:NW-1];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  axil_bram_bridge #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Block RAM stand-in.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=response t=%0t", nm, $time);
  endtask

  function automatic logic in_rng(input logic [31:0] a);
`ifdef AXIL_BRIDGE_RANGE_CHK_EN
    return a[31:AW] == '0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) refm[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic exp_r(input logic [31:0] a);
    if (in_rng(a)) rq.push_back({2'b00, refm[a[AW-1:2]]});
    else rq.push_back({2'b10, 32'd0});
  endtask

  // Monitor: compare each response as it is handed over.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) men_cnt++;
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 34'd1, 34'd0);
        else chk("bresp", {32'd0, bresp}, {32'd0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 34'd1, 34'd0);
        else chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) begin
        bready = $urandom_range(0, 3) != 0;
        rready = $urandom_range(0, 3) != 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_w(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    logic ha, hw;
    int n;
    exp_w(a, d, s);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 100) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk); #1;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      fail_now("aw_w_accept");
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic send_r(input logic [31:0] a);
    logic h;
    int n;
    exp_r(a);
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 100) begin
      h = arready;
      @(posedge clk); #1;
      if (h) arvalid = 1'b0;
      n++;
    end
    if (arvalid) begin
      fail_now("ar_accept");
      arvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      fail_now("drain");
      bq.delete(); rq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] first;
    logic saw_b;
    int n, c0, kind, wi, ri;
    logic [31:0] a, ra;
    for (int i = 0; i < NW; i++) begin
      ram[i] = '0;
      refm[i] = '0;
    end

    do_reset(5);
    chk("rst_awready", {33'd0, awready}, 34'd1);
    chk("rst_wready", {33'd0, wready}, 34'd1);
    chk("rst_arready", {33'd0, arready}, 34'd1);
    chk("rst_valids", {32'd0, bvalid, rvalid}, 34'd0);
    chk("rst_mem_en", {33'd0, mem_en}, 34'd0);
    chk("rst_rdata", {2'd0, rdata}, 34'd0);

    // Write timing: AW+W together.
    exp_w(32'h10, 32'hDEADBEEF, 4'hF);
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_mem_en", {33'd0, mem_en}, 34'd1);
    chk("wr_mem_we", {30'd0, mem_we}, 34'hF);
    chk("wr_mem_addr", {20'd0, mem_addr}, 34'h4);
    chk("wr_mem_wdata", {2'd0, mem_wdata}, {2'd0, 32'hDEADBEEF});
    @(posedge clk); #1;
    chk("wr_bvalid_c2", {33'd0, bvalid}, 34'd1);
    wait_idle();

    // Read timing.
    exp_r(32'h10);
    araddr = 32'h10; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rd_mem_en", {29'd0, mem_en, mem_we}, {29'd0, 1'b1, 4'h0});
    chk("rd_mem_addr", {20'd0, mem_addr}, 34'h4);
    @(posedge clk); #1;
    chk("rd_rvalid_c2", {33'd0, rvalid}, 34'd1);
    chk("rd_rdata_c2", {2'd0, rdata}, {2'd0, 32'hDEADBEEF});
    wait_idle();

    // Partial strobe.
    send_w(32'h10, 32'h11223344, 4'h3);
    wait_idle();
    send_r(32'h12);
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    chk("partial_rdata", {2'd0, rdata}, {2'd0, 32'hDEAD3344});
    wait_idle();

    // Contention after reset: write wins, read next cycle.
    do_reset(2);
    exp_w(32'h80, 32'hA5A5_0001, 4'hF);
    exp_r(32'h40);
    awaddr = 32'h80; wdata = 32'hA5A5_0001; wstrb = 4'hF;
    araddr = 32'h40;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("c1_first_wr", {19'd0, mem_en, mem_we, mem_addr},
        {19'd0, 1'b1, 4'hF, 14'h20});
    @(posedge clk); #1;
    chk("c1_then_rd", {19'd0, mem_en, mem_we, mem_addr},
        {19'd0, 1'b1, 4'h0, 14'h10});
    wait_idle();

    // Lone write makes the next tie go to the read.
    send_w(32'h84, 32'h0BAD_F00D, 4'hF);
    wait_idle();
    exp_w(32'h88, 32'h1357_9BDF, 4'hF);
    exp_r(32'h80);
    awaddr = 32'h88; wdata = 32'h1357_9BDF; wstrb = 4'hF;
    araddr = 32'h80;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("c2_first_rd", {19'd0, mem_en, mem_we, mem_addr},
        {19'd0, 1'b1, 4'h0, 14'h20});
    @(posedge clk); #1;
    chk("c2_then_wr", {19'd0, mem_en, mem_we, mem_addr},
        {19'd0, 1'b1, 4'hF, 14'h22});
    wait_idle();

    // R back-pressure while a write completes.
    rready = 1'b0;
    send_r(32'h84);
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    first = rdata;
    chk("bp_rvalid", {33'd0, rvalid}, 34'd1);
    exp_w(32'h90, 32'h2468_ACE0, 4'hF);
    awaddr = 32'h90; wdata = 32'h2468_ACE0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    saw_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (bvalid) saw_b = 1'b1;
      chk("bp_rdata_stable", {2'd0, rdata}, {2'd0, first});
      chk("bp_arready_low", {33'd0, arready}, 34'd0);
    end
    chk("bp_write_done", {33'd0, saw_b}, 34'd1);
    rready = 1'b1;
    wait_idle();

    // Upper address bits: error or alias depending on build.
    c0 = men_cnt;
    send_r(32'h0001_0000);
    wait_idle();
`ifdef AXIL_BRIDGE_RANGE_CHK_EN
    chk("rng_no_mem_en", men_cnt, c0);
`else
    chk("alias_mem_en", men_cnt, c0 + 1);
`endif
    send_w(32'h0001_0004, 32'h7777_7777, 4'hF);
    wait_idle();
    send_r(32'h4);
    wait_idle();

    // Reset while a write is held: it must vanish.
    awaddr = 32'h10; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("rst_mid_mem_en", {33'd0, mem_en}, 34'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_b", {33'd0, bvalid}, 34'd0);
    end
    send_r(32'h10);
    wait_idle();

    // Randomized traffic with ready stalls.
    rnd_rdy = 1'b1;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      wi = $urandom_range(0, 31);
      ri = wi ^ 1;
      a  = {16'd0, 14'(wi), 2'($urandom_range(0, 3))};
      ra = {16'd0, 14'(ri), 2'($urandom_range(0, 3))};
      if (kind != 2 && $urandom_range(0, 5) == 0) begin
        a[31:16]  = 16'($urandom_range(1, 65535));
        ra[31:16] = 16'($urandom_range(1, 65535));
      end
      if (kind == 0) begin
        send_w(a, $urandom, 4'($urandom_range(0, 15)));
      end else if (kind == 1) begin
        send_r(ra);
      end else begin
        fork
          send_w(a, $urandom, 4'($urandom_range(0, 15)));
          send_r(ra);
        join
      end
      wait_idle();
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 32; i++) send_r({16'd0, 14'(i), 2'b00});
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
